// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the step sequencer controller.
// Holds the controller state encoding and the power-on next-state table.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } ctrl_state_t;

    localparam int NSTATES = 8;
    localparam int SW      = 3;

    // Entry i is packed at slice [i], so DEFAULT_TABLE[0] == 4.
    localparam logic [NSTATES-1:0][SW-1:0] DEFAULT_TABLE = {
        3'd2, 3'd2, 3'd2, 3'd7, 3'd3, 3'd1, 3'd2, 3'd4
    };

endpackage

// File: rtl/seq_tick_div.sv
// Rate divider: tick is high while the count equals div; clears on match.
// The count only returns to zero through clr or a match.
module seq_tick_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;

    assign tick = (count_q == div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tick ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_step_ctrl.sv
// Sequencer controller: programmable next-state table, free-run/single-step
// control FSM, state register, y decode and saturating lap counter.
module seq_step_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int NSTATES = 8,
    parameter int SW      = $clog2(NSTATES),
    parameter int DIV_W   = 8,
    parameter int LAP_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [DIV_W-1:0] div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SW-1:0]    cfg_idx,
    input  logic [SW-1:0]    cfg_next,
    output logic [SW-1:0]    state,
    output logic             y,
    output logic             busy,
    output logic [LAP_W-1:0] laps
);

    ctrl_state_t                ctrl_q;
    logic [SW-1:0]              state_q, state_d;
    logic [LAP_W-1:0]           laps_q, laps_d;
    logic [NSTATES-1:0][SW-1:0] table_q, table_d;
    logic [SW-1:0]              next_val;
    logic                       tick, adv, cfg_fire;

    assign cfg_ready = (ctrl_q == IDLE);
    assign busy      = (ctrl_q != IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign state     = state_q;
    assign y         = (state_q == '0);
    assign laps      = laps_q;

    seq_tick_div #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ctrl_q == RUN),
        .clr     ((ctrl_q == IDLE) && start),
        .div     (div),
        .tick    (tick)
    );

    // Writes and advances never share a cycle: writes only land in IDLE.
    for (genvar gi = 0; gi < NSTATES; gi++) begin : g_table
        assign table_d[gi] = (cfg_fire && (cfg_idx == SW'(gi))) ? cfg_next : table_q[gi];
    end

    assign next_val = table_q[state_q];
    assign adv      = (ctrl_q == STEP) || ((ctrl_q == RUN) && tick);

    always_comb begin
        state_d = state_q;
        laps_d  = laps_q;
        if (adv) begin
            state_d = next_val;
            if ((next_val == '0) && (state_q != '0) && (laps_q != '1)) begin
                laps_d = laps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= IDLE;
        end else begin
            case (ctrl_q)
                IDLE: begin
                    if (start) begin
                        ctrl_q <= RUN;
                    end else if (step) begin
                        ctrl_q <= STEP;
                    end
                end
                RUN: begin
                    if (stop) begin
                        ctrl_q <= IDLE;
                    end
                end
                STEP:    ctrl_q <= IDLE;
                default: ctrl_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
            laps_q  <= '0;
            for (int i = 0; i < NSTATES; i++) begin
                table_q[i] <= SW'(DEFAULT_TABLE[i % seq_ctrl_pkg::NSTATES]);
            end
        end else begin
            state_q <= state_d;
            laps_q  <= laps_d;
            table_q <= table_d;
        end
    end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Self-checking bench for seq_step_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural model.
module tb_seq_step_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, start, stop, step, cfg_valid;
    logic [7:0] div;
    logic [2:0] cfg_idx, cfg_next;
    logic       cfg_ready, y, busy;
    logic [2:0] state;
    logic [7:0] laps;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=idle, 1=free-run, 2=single-step pending.
    int m_state, m_mode, m_cnt, m_laps;
    int m_tab[8];

    seq_step_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .div       (div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_next  (cfg_next),
        .state     (state),
        .y         (y),
        .busy      (busy),
        .laps      (laps)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_mode  = 0;
        m_cnt   = 0;
        m_laps  = 0;
        m_tab   = '{4, 2, 1, 3, 7, 2, 2, 2};
    endfunction

    function automatic void model_edge();
        bit advance = 0;
        int nxt;
        case (m_mode)
            0: begin
                if (cfg_valid) m_tab[cfg_idx] = int'(cfg_next);
                if (start) begin
                    m_mode = 1;
                    m_cnt  = 0;
                end else if (step) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (m_cnt == int'(div)) begin
                    advance = 1;
                    m_cnt   = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % 256;
                end
                if (stop) m_mode = 0;
            end
            default: begin
                advance = 1;
                m_mode  = 0;
            end
        endcase
        if (advance) begin
            nxt = m_tab[m_state];
            if (nxt == 0 && m_state != 0 && m_laps < 255) m_laps++;
            m_state = nxt;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_state"}, int'(state), m_state);
        check_eq({tag, "_y"}, int'(y), int'(m_state == 0));
        check_eq({tag, "_busy"}, int'(busy), int'(m_mode != 0));
        check_eq({tag, "_cfg_ready"}, int'(cfg_ready), int'(m_mode == 0));
        check_eq({tag, "_laps"}, int'(laps), m_laps);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        $display("%s t=%0t st=%0d y=%0b busy=%0b rdy=%0b laps=%0d", tag, $time,
                 state, y, busy, cfg_ready, laps);
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        stop      = 1'b0;
        step      = 1'b0;
        cfg_valid = 1'b0;
        cfg_idx   = 3'd0;
        cfg_next  = 3'd0;
    endtask

    task automatic cfg_write(input int idx, input int nxt);
        cfg_valid = 1'b1;
        cfg_idx   = 3'(idx);
        cfg_next  = 3'(nxt);
        cycle("cfg");
        cfg_valid = 1'b0;
    endtask

    int exp1[6] = '{4, 7, 2, 1, 2, 1};

    initial begin
        reset_n = 1'b0;
        div     = 8'd0;
        idle_inputs();
        model_reset();
        #12;
        reset_n = 1'b1;
        check_outputs("reset");

        // 1: single-step through the default table
        for (int k = 0; k < 6; k++) begin
            step = 1'b1;
            cycle("t1_req");
            step = 1'b0;
            cycle("t1_adv");
            check_eq("t1_seq", int'(state), exp1[k]);
        end
        check_eq("t1_laps", int'(laps), 0);

        // 2: 0<->1 loop at full rate
        cfg_write(0, 1);
        cfg_write(1, 0);
        div   = 8'd0;
        start = 1'b1;
        cycle("t2_start");
        start = 1'b0;
        repeat (10) cycle("t2_run");
        stop = 1'b1;
        cycle("t2_stop");
        stop = 1'b0;
        cycle("t2_idle");

        // 3: divided rate, then a one-cycle stop
        div   = 8'd3;
        start = 1'b1;
        cycle("t3_start");
        start = 1'b0;
        repeat (20) cycle("t3_run");
        stop = 1'b1;
        cycle("t3_stop");
        stop = 1'b0;
        check_eq("t3_cfg_ready", int'(cfg_ready), 1);
        repeat (3) cycle("t3_frozen");

        // 4: config request stalls while running
        div   = 8'd2;
        start = 1'b1;
        cycle("t4_start");
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_idx   = 3'd2;
        cfg_next  = 3'd5;
        repeat (5) cycle("t4_stall");
        check_eq("t4_ready_low", int'(cfg_ready), 0);
        stop = 1'b1;
        cycle("t4_stop");
        stop = 1'b0;
        cycle("t4_write");
        cfg_valid = 1'b0;
        cfg_write(5, 0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cycle("t4_req");
            step = 1'b0;
            cycle("t4_adv");
        end

        // 5: lap counter saturation
        cfg_write(0, 1);
        cfg_write(1, 0);
        div   = 8'd0;
        start = 1'b1;
        cycle("t5_start");
        start = 1'b0;
        repeat (620) cycle("t5_run");
        stop = 1'b1;
        cycle("t5_stop");
        stop = 1'b0;
        check_eq("t5_laps_sat", int'(laps), 255);

        // 6: asynchronous reset mid-run, between clock edges
        div   = 8'd1;
        start = 1'b1;
        cycle("t6_start");
        start = 1'b0;
        repeat (7) cycle("t6_run");
        #2;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check_eq("t6_rst_state", int'(state), 0);
        check_eq("t6_rst_y", int'(y), 1);
        check_eq("t6_rst_busy", int'(busy), 0);
        check_eq("t6_rst_ready", int'(cfg_ready), 1);
        check_eq("t6_rst_laps", int'(laps), 0);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cycle("t6_req");
            step = 1'b0;
            cycle("t6_adv");
            check_eq("t6_seq", int'(state), exp1[k]);
        end

        // Random stimulus; div only changes while idle
        for (int n = 0; n < 2000; n++) begin
            if (m_mode == 0) div = 8'($urandom_range(0, 3));
            start     = ($urandom % 8) == 0;
            stop      = ($urandom % 6) == 0;
            step      = ($urandom % 4) == 0;
            cfg_valid = ($urandom % 5) == 0;
            cfg_idx   = 3'($urandom);
            cfg_next  = 3'($urandom_range(0, 2));
            cycle("rnd");
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
